uart_rx_framer: RTL and testbench

Parametrised packet framer between a byte-wide UART receiver and an AXI-stream consumer such as the gzip compressor. It groups received bytes into packets, closing a packet on an idle gap or on a maximum length. It buffers bytes in a FIFO so that consumer backpressure (`o_tready` low) never stalls the UART. It detects overflow and drops bytes safely, guaranteeing every packet that delivers any byte also delivers its `tlast`.

---
 rtl/uart_rx_framer_pkg.sv | 22 ++
 rtl/uart_rx_framer_if.sv | 31 +++
 rtl/uart_rx_framer_fifo.sv | 66 ++++++
 rtl/uart_rx_framer.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_framer.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_framer_pkg.sv
// Shared types and constants for the UART receive packet framer.
package uart_rx_framer_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned ENTRY_W    = BYTE_W + 1;
    localparam int unsigned DROP_CNT_W = 16;

    // Framer state: nothing staged, byte staged with gap timer running,
    // staged byte must close the packet on the next cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // One FIFO entry: packet-end flag above the data byte.
    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/uart_rx_framer_if.sv
// Byte input strobe plus AXI-stream style output of the framer.
// master: the framer side; slave: the UART source / stream consumer side.
interface uart_rx_framer_if;
    import uart_rx_framer_pkg::*;

    logic              i_en;
    logic [BYTE_W-1:0] i_data;
    logic              o_tready;
    logic              o_tvalid;
    logic [BYTE_W-1:0] o_tdata;
    logic              o_tlast;

    modport master (
        input  i_en,
        input  i_data,
        input  o_tready,
        output o_tvalid,
        output o_tdata,
        output o_tlast
    );

    modport slave (
        output i_en,
        output i_data,
        output o_tready,
        input  o_tvalid,
        input  o_tdata,
        input  o_tlast
    );

endinterface

// File: rtl/uart_rx_framer_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head entry.
// count reports total occupancy (storage array plus head register).
module uart_rx_framer_fifo
    import uart_rx_framer_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  entry_t              wr_data,
    input  logic                rd_en,
    output logic                rd_valid,
    output entry_t              rd_data,
    output logic [DEPTH_LOG2:0] count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;

    entry_t                mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [DEPTH_LOG2:0]   mem_cnt;
    logic                  head_load;

    // The head register refills whenever it is empty or being consumed.
    assign head_load = (mem_cnt != '0) && (!rd_valid || rd_en);
    assign count     = mem_cnt + {{DEPTH_LOG2{1'b0}}, rd_valid};

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= wr_data;
        end
    end

    // Pointers, array occupancy and the registered head entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            mem_cnt  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + PTR_ONE;
            end
            if (head_load) begin
                rptr     <= rptr + PTR_ONE;
                rd_data  <= mem[rptr];
                rd_valid <= 1'b1;
            end else if (rd_en) begin
                rd_valid <= 1'b0;
            end
            case ({wr_en, head_load})
                2'b10:   mem_cnt <= mem_cnt + CNT_ONE;
                2'b01:   mem_cnt <= mem_cnt - CNT_ONE;
                default: mem_cnt <= mem_cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_framer.sv
// Packet framer between a byte-wide UART receiver and a stream consumer.
// Packets close on an idle gap or on reaching MAX_LEN bytes; a FIFO absorbs
// consumer backpressure and overflow drops whole-or-tail-safe.
// Optional feature macro: UART_RX_FRAMER_DROP_CNT_EN (saturating drop counter).
module uart_rx_framer
    import uart_rx_framer_pkg::*;
#(
    parameter int unsigned GAP_CYCLES      = 100000,
    parameter int unsigned MAX_LEN         = 65536,
    parameter int unsigned FIFO_DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_rx_framer_if.master      bus,
    output logic                  o_busy,
    output logic                  o_drop,
    output logic [DROP_CNT_W-1:0] o_drop_cnt
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES);
    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned CNT_W = FIFO_DEPTH_LOG2 + 1;

    localparam logic [LEN_W-1:0] LEN_ONE = 1;
    localparam logic [GAP_W-1:0] GAP_ONE = 1;

    state_t            state;
    state_t            state_nxt;
    logic [BYTE_W-1:0] stage_data;
    logic [LEN_W-1:0]  len;
    logic [GAP_W-1:0]  gap;
    logic              pkt_has_data;

    logic              len_at_max;
    logic              gap_done;
    logic              push_req;
    logic              push_last;
    logic              push_ok;
    logic              stage_load;
    logic              pkt_start;

    logic              fifo_wr;
    logic              fifo_rd;
    logic              fifo_valid;
    entry_t            fifo_head;
    entry_t            push_entry;
    logic [CNT_W-1:0]  fifo_count;

    assign len_at_max = (len == LEN_W'(MAX_LEN - 1));
    assign gap_done   = (gap == GAP_W'(GAP_CYCLES - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a byte arriving on the gap-expiry cycle keeps the packet open.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.i_en) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.i_en) begin
                    if (len_at_max) begin
                        state_nxt = FLUSH;
                    end
                end else if (gap_done) begin
                    state_nxt = IDLE;
                end
            end
            FLUSH: begin
                state_nxt = bus.i_en ? HOLD : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: push request, acceptance against FIFO room, drop strobe, busy.
    always_comb begin
        push_req   = 1'b0;
        push_last  = 1'b0;
        stage_load = 1'b0;
        pkt_start  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_en) begin
                    stage_load = 1'b1;
                    pkt_start  = 1'b1;
                end
            end
            HOLD: begin
                if (bus.i_en) begin
                    push_req   = 1'b1;
                    stage_load = 1'b1;
                end else if (gap_done) begin
                    push_req  = 1'b1;
                    push_last = 1'b1;
                end
            end
            FLUSH: begin
                push_req  = 1'b1;
                push_last = 1'b1;
                if (bus.i_en) begin
                    stage_load = 1'b1;
                    pkt_start  = 1'b1;
                end
            end
            default: ;
        endcase

        // Body bytes leave one slot spare so a packet with any accepted byte
        // always has room for its closing byte.
        if (push_last) begin
            push_ok = (fifo_count < CNT_W'(DEPTH)) && (pkt_has_data || (len == LEN_ONE));
        end else begin
            push_ok = (fifo_count < CNT_W'(DEPTH - 1));
        end

        fifo_wr = push_req && push_ok;
        o_drop  = push_req && !push_ok;
        o_busy  = (state != IDLE);
    end

    // Staging register, length and gap counters, per-packet acceptance flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_data   <= '0;
            len          <= '0;
            gap          <= '0;
            pkt_has_data <= 1'b0;
        end else begin
            if (stage_load) begin
                stage_data <= bus.i_data;
            end
            if (pkt_start) begin
                len <= LEN_ONE;
                gap <= '0;
            end else if (state == HOLD && bus.i_en) begin
                len <= len + LEN_ONE;
                gap <= '0;
            end else if (state == HOLD) begin
                gap <= gap + GAP_ONE;
            end
            if (pkt_start) begin
                pkt_has_data <= 1'b0;
            end else if (fifo_wr) begin
                pkt_has_data <= 1'b1;
            end
        end
    end

    assign push_entry = '{last: push_last, data: stage_data};
    assign fifo_rd    = fifo_valid && bus.o_tready;

    uart_rx_framer_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (fifo_wr),
        .wr_data  (push_entry),
        .rd_en    (fifo_rd),
        .rd_valid (fifo_valid),
        .rd_data  (fifo_head),
        .count    (fifo_count)
    );

    assign bus.o_tvalid = fifo_valid;
    assign bus.o_tdata  = fifo_head.data;
    assign bus.o_tlast  = fifo_head.last;

`ifdef UART_RX_FRAMER_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt;

    // Saturating count of refused pushes, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (o_drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end

    assign o_drop_cnt = drop_cnt;
`else
    assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer: directed scenarios plus randomized
// traffic checked against a packet-level reference model.
module tb_uart_rx_framer;

    localparam int G     = 16;
    localparam int ML    = 4;
    localparam int DEPTH = 4;

`ifdef UART_RX_FRAMER_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        o_busy;
    logic        o_drop;
    logic [15:0] o_drop_cnt;

    uart_rx_framer_if bus_if ();

    uart_rx_framer #(
        .GAP_CYCLES      (G),
        .MAX_LEN         (ML),
        .FIFO_DEPTH_LOG2 (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
        .o_busy     (o_busy),
        .o_drop     (o_drop),
        .o_drop_cnt (o_drop_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: pending byte awaiting its packet-end decision,
    // and the queue of entries the FIFO should be holding.
    logic [8:0] m_q [$];
    bit         m_pending;
    bit         m_close_next;
    bit         m_pkt_pushed;
    logic [7:0] m_pend_byte;
    int         m_pkt_bytes;
    int         m_quiet;
    int         m_drops;
    bit         exp_drop;
    int         occ;
    bit         held;
    logic [8:0] held_word;

    logic [8:0] seen [$];
    int         seen_cyc [$];
    int         drop_pulses = 0;

    task automatic emit(input logic [7:0] b, input bit last);
        bit ok;
        if (last) ok = (occ < DEPTH) && (m_pkt_pushed || m_pkt_bytes == 1);
        else      ok = (occ < DEPTH - 1);
        if (ok) begin
            m_q.push_back({last, b});
            m_pkt_pushed = 1'b1;
        end else begin
            exp_drop = 1'b1;
        end
    endtask

    task automatic begin_packet(input logic [7:0] b);
        m_pending    = 1'b1;
        m_pend_byte  = b;
        m_pkt_bytes  = 1;
        m_quiet      = 0;
        m_pkt_pushed = 1'b0;
    endtask

    // Scoreboard: evaluated mid-cycle while inputs are stable.
    always @(negedge clk) begin
        logic [8:0]  want;
        logic [15:0] want_cnt;
        if (rst) begin
            m_q.delete();
            m_pending    = 1'b0;
            m_close_next = 1'b0;
            m_pkt_pushed = 1'b0;
            m_pkt_bytes  = 0;
            m_quiet      = 0;
            m_drops      = 0;
            held         = 1'b0;
        end else begin
            n_tests++;
            if (o_busy !== m_pending) begin
                n_fail++;
                $display("FAIL busy @%0d: got %b expected %b", cyc, o_busy, m_pending);
            end
            want_cnt = CNT_EN ? 16'(m_drops) : 16'd0;
            n_tests++;
            if (o_drop_cnt !== want_cnt) begin
                n_fail++;
                $display("FAIL drop_cnt @%0d: got %0d expected %0d", cyc, o_drop_cnt, want_cnt);
            end
            if (held) begin
                n_tests++;
                if ({bus_if.o_tvalid, bus_if.o_tlast, bus_if.o_tdata} !== {1'b1, held_word}) begin
                    n_fail++;
                    $display("FAIL stall_hold @%0d: got v=%b %h expected v=1 %h", cyc,
                             bus_if.o_tvalid, {bus_if.o_tlast, bus_if.o_tdata}, held_word);
                end
            end
            occ = m_q.size();
            n_tests++;
            if (bus_if.o_tvalid === 1'b1 && occ == 0) begin
                n_fail++;
                $display("FAIL spurious_valid @%0d: got tvalid=1 expected 0", cyc);
            end
            if (bus_if.o_tvalid === 1'b1 && bus_if.o_tready === 1'b1) begin
                if (occ != 0) begin
                    want = m_q.pop_front();
                    n_tests++;
                    if ({bus_if.o_tlast, bus_if.o_tdata} !== want) begin
                        n_fail++;
                        $display("FAIL out_word @%0d: got %h expected %h", cyc,
                                 {bus_if.o_tlast, bus_if.o_tdata}, want);
                    end
                end
                seen.push_back({bus_if.o_tlast, bus_if.o_tdata});
                seen_cyc.push_back(cyc);
            end

            exp_drop = 1'b0;
            if (m_close_next) begin
                emit(m_pend_byte, 1'b1);
                m_close_next = 1'b0;
                if (bus_if.i_en) begin_packet(bus_if.i_data);
                else             m_pending = 1'b0;
            end else if (m_pending) begin
                if (bus_if.i_en) begin
                    emit(m_pend_byte, 1'b0);
                    m_pend_byte = bus_if.i_data;
                    m_pkt_bytes++;
                    m_quiet = 0;
                    if (m_pkt_bytes == ML) m_close_next = 1'b1;
                end else if (m_quiet == G - 1) begin
                    emit(m_pend_byte, 1'b1);
                    m_pending = 1'b0;
                end else begin
                    m_quiet++;
                end
            end else if (bus_if.i_en) begin
                begin_packet(bus_if.i_data);
            end

            n_tests++;
            if (o_drop !== exp_drop) begin
                n_fail++;
                $display("FAIL drop @%0d: got %b expected %b", cyc, o_drop, exp_drop);
            end
            if (o_drop === 1'b1) drop_pulses++;
            if (exp_drop && m_drops < 65535) m_drops++;
            held      = (bus_if.o_tvalid === 1'b1) && (bus_if.o_tready !== 1'b1);
            held_word = {bus_if.o_tlast, bus_if.o_tdata};
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        bus_if.i_en   = 1'b1;
        bus_if.i_data = d;
        @(posedge clk);
        #1;
        bus_if.i_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.o_tready = 1'b0;
        idle(3);
        n_tests++;
        if ({bus_if.o_tvalid, bus_if.o_tdata, bus_if.o_tlast, o_busy, o_drop, o_drop_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%h l=%b busy=%b drop=%b cnt=%0d expected all 0",
                     bus_if.o_tvalid, bus_if.o_tdata, bus_if.o_tlast, o_busy, o_drop, o_drop_cnt);
        end
        rst = 1'b0;
        idle(2);
        n_tests++;
        if ({bus_if.o_tvalid, o_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: got v=%b busy=%b expected 0 0", bus_if.o_tvalid, o_busy);
        end
    endtask

    task automatic test_gap_close();
        logic [8:0] want [3] = '{9'h011, 9'h022, 9'h133};
        int c0;
        bus_if.o_tready = 1'b1;
        seen.delete();
        seen_cyc.delete();
        send_byte(8'h11); idle(4);
        send_byte(8'h22); idle(4);
        send_byte(8'h33); c0 = cyc;
        idle(G + 6);
        n_tests++;
        if (seen.size() != 3) begin
            n_fail++;
            $display("FAIL gap_count: got %0d expected 3", seen.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (seen[i] !== want[i]) begin
                    n_fail++;
                    $display("FAIL gap_word%0d: got %h expected %h", i, seen[i], want[i]);
                end
            end
            n_tests++;
            if (seen_cyc[2] - c0 != G + 1) begin
                n_fail++;
                $display("FAIL gap_latency: got %0d expected %0d", seen_cyc[2] - c0, G + 1);
            end
        end
    endtask

    task automatic test_max_len();
        logic [8:0] want [6] = '{9'h001, 9'h002, 9'h003, 9'h104, 9'h005, 9'h106};
        int c4;
        bus_if.o_tready = 1'b1;
        seen.delete();
        seen_cyc.delete();
        c4 = 0;
        for (int i = 1; i <= 6; i++) begin
            send_byte(8'(i));
            if (i == 4) c4 = cyc;
            idle(2);
        end
        idle(G + 6);
        n_tests++;
        if (seen.size() != 6) begin
            n_fail++;
            $display("FAIL maxlen_count: got %0d expected 6", seen.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_tests++;
                if (seen[i] !== want[i]) begin
                    n_fail++;
                    $display("FAIL maxlen_word%0d: got %h expected %h", i, seen[i], want[i]);
                end
            end
            n_tests++;
            if (seen_cyc[3] - c4 != 2) begin
                n_fail++;
                $display("FAIL maxlen_latency: got %0d expected 2", seen_cyc[3] - c4);
            end
        end
    endtask

    task automatic test_gap_race();
        bus_if.o_tready = 1'b1;
        seen.delete();
        seen_cyc.delete();
        send_byte(8'h5A);
        idle(G - 1);
        send_byte(8'h5B);
        idle(G + 6);
        n_tests++;
        if (seen.size() != 2) begin
            n_fail++;
            $display("FAIL race_count: got %0d expected 2", seen.size());
        end else begin
            n_tests++;
            if (seen[0] !== 9'h05A || seen[1] !== 9'h15B) begin
                n_fail++;
                $display("FAIL race_words: got %h %h expected 05a 15b", seen[0], seen[1]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [8:0] want [4] = '{9'h0A0, 9'h0A1, 9'h0A2, 9'h1A3};
        int d0;
        bus_if.o_tready = 1'b0;
        seen.delete();
        seen_cyc.delete();
        d0 = drop_pulses;
        for (int i = 0; i < 8; i++) begin
            send_byte(8'hA0 + 8'(i));
            idle(1);
        end
        idle(G + 4);
        n_tests++;
        if (drop_pulses - d0 != 4) begin
            n_fail++;
            $display("FAIL ovf_drops: got %0d expected 4", drop_pulses - d0);
        end
        n_tests++;
        if (o_drop_cnt !== (CNT_EN ? 16'd4 : 16'd0)) begin
            n_fail++;
            $display("FAIL ovf_cnt: got %0d expected %0d", o_drop_cnt, CNT_EN ? 4 : 0);
        end
        send_byte(8'hB0); idle(1);
        send_byte(8'hB1);
        idle(G + 4);
        n_tests++;
        if (drop_pulses - d0 != 6) begin
            n_fail++;
            $display("FAIL full_drops: got %0d expected 6", drop_pulses - d0);
        end
        n_tests++;
        if (o_drop_cnt !== (CNT_EN ? 16'd6 : 16'd0)) begin
            n_fail++;
            $display("FAIL full_cnt: got %0d expected %0d", o_drop_cnt, CNT_EN ? 6 : 0);
        end
        n_tests++;
        if ({bus_if.o_tvalid, bus_if.o_tlast, bus_if.o_tdata} !== 10'h2A0) begin
            n_fail++;
            $display("FAIL full_head: got v=%b %h expected v=1 0a0", bus_if.o_tvalid,
                     {bus_if.o_tlast, bus_if.o_tdata});
        end
        bus_if.o_tready = 1'b1;
        idle(10);
        n_tests++;
        if (seen.size() != 4) begin
            n_fail++;
            $display("FAIL drain_count: got %0d expected 4", seen.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (seen[i] !== want[i]) begin
                    n_fail++;
                    $display("FAIL drain_word%0d: got %h expected %h", i, seen[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        bus_if.o_tready = 1'b0;
        seen.delete();
        seen_cyc.delete();
        send_byte(8'hC0); idle(1);
        send_byte(8'hC1); idle(1);
        send_byte(8'hC2); idle(2);
        n_tests++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_rst_busy: got %b expected 1", o_busy);
        end
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        n_tests++;
        if ({bus_if.o_tvalid, o_busy, o_drop_cnt} !== 18'd0) begin
            n_fail++;
            $display("FAIL rst_mid: got v=%b busy=%b cnt=%0d expected 0 0 0",
                     bus_if.o_tvalid, o_busy, o_drop_cnt);
        end
        bus_if.o_tready = 1'b1;
        send_byte(8'hD0); idle(2);
        send_byte(8'hD1);
        idle(G + 6);
        n_tests++;
        if (seen.size() != 2) begin
            n_fail++;
            $display("FAIL post_rst_count: got %0d expected 2", seen.size());
        end else begin
            n_tests++;
            if (seen[0] !== 9'h0D0 || seen[1] !== 9'h1D1) begin
                n_fail++;
                $display("FAIL post_rst_words: got %h %h expected 0d0 1d1", seen[0], seen[1]);
            end
        end
    endtask

    task automatic test_random();
        int p_en  [6] = '{90, 50, 10, 3, 70, 30};
        int p_rdy [6] = '{100, 50, 90, 20, 10, 80};
        for (int ph = 0; ph < 6; ph++) begin
            for (int k = 0; k < 500; k++) begin
                rst             = ($urandom_range(0, 799) == 0);
                bus_if.i_en     = ($urandom_range(0, 99) < p_en[ph]);
                bus_if.i_data   = 8'($urandom);
                bus_if.o_tready = ($urandom_range(0, 99) < p_rdy[ph]);
                @(posedge clk);
                #1;
            end
        end
        rst             = 1'b0;
        bus_if.i_en     = 1'b0;
        bus_if.o_tready = 1'b1;
        idle(G + DEPTH + 10);
        n_tests++;
        if (m_q.size() != 0 || o_busy !== 1'b0 || bus_if.o_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL random_drain: got left=%0d busy=%b v=%b expected 0 0 0",
                     m_q.size(), o_busy, bus_if.o_tvalid);
        end
    endtask

    initial begin
        bus_if.i_en     = 1'b0;
        bus_if.i_data   = 8'h00;
        bus_if.o_tready = 1'b0;
        test_reset();
        test_gap_close();
        test_max_len();
        test_gap_race();
        test_overflow();
        test_reset_mid_packet();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
